// File: rtl/switch_debouncer.sv
// Switch debouncer: two-flop synchroniser followed by a stable-time qualifier FSM.
// Produces a registered debounced level and a one-cycle tick on each qualified press.
module switch_debouncer #(
    parameter int ClkFreq    = 100_000_000,
    parameter int StableTime = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic db_level_o,
    output logic db_tick_o
);

    localparam int N  = (ClkFreq / 1000) * StableTime;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    logic          sync1_r;
    logic          sync2_r;
    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          tick_r;

    // Two-flop synchroniser bringing the raw switch into the clock domain.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= sw_i;
            sync2_r <= sync1_r;
        end
    end

    // Qualifier FSM; the level register tracks the next state so it reads 1 in ONE/WAIT0.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r <= ZERO;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            case (state_r)
                ZERO: begin
                    level_r <= 1'b0;
                    if (sync2_r) begin
                        state_r <= WAIT1;
                        cnt_r   <= CNT_LOAD;
                    end
                end
                WAIT1: begin
                    if (!sync2_r) begin
                        state_r <= ZERO;
                        level_r <= 1'b0;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_r <= ONE;
                        level_r <= 1'b1;
                        tick_r  <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                        level_r <= 1'b0;
                    end
                end
                ONE: begin
                    level_r <= 1'b1;
                    if (!sync2_r) begin
                        state_r <= WAIT0;
                        cnt_r   <= CNT_LOAD;
                    end
                end
                WAIT0: begin
                    // Falling qualification never produces a tick.
                    if (sync2_r) begin
                        state_r <= ONE;
                        level_r <= 1'b1;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_r <= ZERO;
                        level_r <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                        level_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ZERO;
                    cnt_r   <= CNT_ZERO;
                    level_r <= 1'b0;
                end
            endcase
        end
    end

    assign db_level_o = level_r;
    assign db_tick_o  = tick_r;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with N=1000 stable cycles.
// A run-length reference model is compared against the DUT on every falling edge.
module tb_switch_debouncer;

    localparam int N = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sw  = 1'b0;
    logic db_level;
    logic db_tick;

    int checks   = 0;
    int failures = 0;
    int ticks    = 0;
    bit mon_en   = 1'b0;
    logic prev_tick = 1'b0;

    // Reference model: level flips once N+1 consecutive synchronised samples disagree with it.
    logic m_p1    = 1'b0;
    logic m_p2    = 1'b0;
    logic m_level = 1'b0;
    logic m_tick  = 1'b0;
    int   m_run   = 0;

    switch_debouncer #(
        .ClkFreq    (1_000_000),
        .StableTime (1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sw_i       (sw),
        .db_level_o (db_level),
        .db_tick_o  (db_tick)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model update on each active edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_p1    <= 1'b0;
            m_p2    <= 1'b0;
            m_level <= 1'b0;
            m_tick  <= 1'b0;
            m_run   <= 0;
        end else begin
            m_p1 <= sw;
            m_p2 <= m_p1;
            if (m_p2 != m_level) begin
                if (m_run == N) begin
                    m_level <= ~m_level;
                    m_tick  <= ~m_level;
                    m_run   <= 0;
                end else begin
                    m_run  <= m_run + 1;
                    m_tick <= 1'b0;
                end
            end else begin
                m_run  <= 0;
                m_tick <= 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, plus tick bookkeeping.
    always @(negedge clk) begin
        if (mon_en) begin
            check_value("level_vs_model", int'(db_level), int'(m_level));
            check_value("tick_vs_model", int'(db_tick), int'(m_tick));
            check_value("tick_consecutive", int'(prev_tick & db_tick), 0);
            prev_tick <= db_tick;
            if (db_tick === 1'b1) ticks <= ticks + 1;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts edges from the next one (index 0) until db_level reaches target.
    task automatic measure_edge(input string tag, input logic target, input int exp);
        int found;
        found = -1;
        for (int i = 0; i < 3000 && found < 0; i++) begin
            @(posedge clk);
            #1;
            if (db_level === target) found = i;
        end
        check_value(tag, found, exp);
    endtask

    initial begin
        int t0;
        int total;
        int len;
        logic val;

        // Reset held with the switch already pressed.
        rst = 1'b0;
        sw  = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check_value("rst_level", int'(db_level), 0);
            check_value("rst_tick", int'(db_tick), 0);
        end
        hold(1);
        rst = 1'b1;
        t0 = ticks;
        measure_edge("rst_release_rise", 1'b1, N + 2);
        hold(10);
        check_value("rst_release_ticks", ticks - t0, 1);

        // Clean release from ONE.
        sw = 1'b0;
        t0 = ticks;
        measure_edge("release_fall", 1'b0, N + 2);
        hold(10);
        check_value("release_ticks", ticks - t0, 0);

        // Clean press held for 2000 cycles.
        hold(20);
        sw = 1'b1;
        t0 = ticks;
        measure_edge("press_rise", 1'b1, N + 2);
        hold(2000 - (N + 3));
        check_value("press_ticks", ticks - t0, 1);
        check_value("press_level", int'(db_level), 1);

        // Low glitch of N-1 cycles in ONE, then a real release.
        sw = 1'b0;
        hold(N - 1);
        sw = 1'b1;
        t0 = ticks;
        hold(20);
        check_value("rel_glitch_level", int'(db_level), 1);
        sw = 1'b0;
        measure_edge("rel_fall", 1'b0, N + 2);
        hold(10);
        check_value("rel_ticks", ticks - t0, 0);

        // High pulse of N-1 cycles is rejected, N+1 cycles qualifies.
        hold(20);
        t0 = ticks;
        sw = 1'b1;
        hold(N - 1);
        sw = 1'b0;
        hold(1100);
        check_value("pulse999_level", int'(db_level), 0);
        check_value("pulse999_ticks", ticks - t0, 0);
        sw = 1'b1;
        hold(N + 1);
        sw = 1'b0;
        hold(20);
        check_value("pulse1001_level", int'(db_level), 1);
        check_value("pulse1001_ticks", ticks - t0, 1);
        hold(1100);
        check_value("pulse1001_fall", int'(db_level), 0);

        // Bouncy press with random runs of 1..50 cycles.
        t0 = ticks;
        total = 0;
        val = 1'b1;
        while (total < 500) begin
            len = int'($urandom_range(50, 1));
            sw = val;
            hold(len);
            total += len;
            val = ~val;
        end
        sw = 1'b0;
        hold(3);
        check_value("bounce_hold_level", int'(db_level), 0);
        check_value("bounce_hold_ticks", ticks - t0, 0);
        sw = 1'b1;
        measure_edge("bounce_rise", 1'b1, N + 2);
        hold(10);
        check_value("bounce_ticks", ticks - t0, 1);

        // Reset in the middle of a rising qualification.
        sw = 1'b0;
        hold(1100);
        check_value("midrst_idle_level", int'(db_level), 0);
        sw = 1'b1;
        hold(502);
        t0 = ticks;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_value("midrst_level", int'(db_level), 0);
        check_value("midrst_tick", int'(db_tick), 0);
        hold(1);
        rst = 1'b1;
        measure_edge("midrst_rise", 1'b1, N + 2);
        hold(10);
        check_value("midrst_ticks", ticks - t0, 1);

        hold(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Debounces one asynchronous mechanical switch/button input and produces a clean level and a single-cycle rising-edge tick. Placed directly behind board I/O pins, ahead of any control logic that consumes user inputs. Synchronises `sw_i` into the clock domain, then requires the synchronised value to stay stable for `StableTime` ms before it changes the output level.

## Interface
- `ClkFreq`, default 100_000_000: clock frequency in Hz; integer, at least 1000.
- `StableTime`, default 10: required stable time in ms; integer, at least 1.
- Derived constant `N = (ClkFreq/1000)*StableTime`, the stable-cycle count. Requirement: N ≥ 2.
- Derived counter width: `$clog2(N+1)` bits.
- One clock; reset is synchronous and active-low.
- `clk_i`  in  1  single system clock; all state updates on its rising edge.
- `rst_i`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk_i`.
- `sw_i`  in  1  raw switch input; asynchronous and bouncy.
- `db_level_o`  out  1  debounced switch level; registered.
- `db_tick_o`  out  1  one-cycle pulse on each 0→1 change of `db_level_o`; registered.

## Operation
- **Synchroniser:** two-flop chain `sync1 <= sw_i`, `sync2 <= sync1`. Only `sync2` (called `s` below) feeds the FSM.
- **FSM states:** ZERO, WAIT1, ONE, WAIT0. It has one down-counter `cnt`.
  - ZERO: `db_level_o`=0. If `s`=1, go to WAIT1 and load `cnt` = N-1.
  - WAIT1: `db_level_o`=0.
    - If `s`=0, go to ZERO. Partial counts are discarded.
    - Else if `cnt`=0, go to ONE and assert `db_tick_o` for one cycle.
    - Else decrement `cnt`.
  - ONE: `db_level_o`=1. If `s`=0, go to WAIT0 and load `cnt` = N-1.
  - WAIT0: `db_level_o`=1.
    - If `s`=1, go to ONE.
    - Else if `cnt`=0, go to ZERO. No tick is generated.
    - Else decrement `cnt`.
- **Outputs:** both outputs are registered, so `db_level_o` equals 1 exactly when the state is ONE or WAIT0.
- **`db_tick_o`:** high for exactly one clock, in the same cycle `db_level_o` first reads 1.
- **Bounce handling:** any bounce during a WAIT state restarts the full qualification on the next transition attempt. Output never toggles on pulses shorter than N cycles of synchronised input.
- **Reset (`rst_i`=0 at a clock edge):**
  - `sync1`, `sync2` → 0; state → ZERO; `cnt` → 0.
  - `db_level_o` → 0 and `db_tick_o` → 0.
  - Reset overrides all other activity, including mid-WAIT.
  - After release, a switch already held high qualifies normally; a tick is produced.
- **Counter:** width `$clog2(N+1)`; it never wraps. Loads only on ZERO→WAIT1 and ONE→WAIT0.

## Timing
- Let edge E be the first rising edge sampling `sw_i`=1, with `sw_i` held high afterwards from state ZERO:
  - `s`=1 after E+1.
  - FSM enters WAIT1 at E+2.
  - `db_level_o`=1 and `db_tick_o`=1 after edge E+2+N.
  - `db_tick_o` returns to 0 after E+3+N.
- Release is symmetric: `db_level_o` falls after E'+2+N, where E' is the first edge sampling `sw_i`=0. No tick.
- A low-going glitch on `sw_i` of k < N cycles while in ONE leaves `db_level_o`=1 throughout. The same holds for high-going glitches in ZERO.
- At most one tick per qualified press. `db_tick_o` is never high for two consecutive cycles.
- Reset values of all outputs are 0, valid the cycle after the reset edge.

## Test plan
Overrides for all scenarios: `ClkFreq`=1_000_000, `StableTime`=1, so N=1000.
1. **Reset:** hold `rst_i`=0 for 5 cycles with `sw_i`=1 → `db_level_o`=0 and `db_tick_o`=0 throughout. After release, `db_level_o` rises 1002 edges later, with one tick.
2. **Clean press:** from idle, set `sw_i`=1 and hold for 2000 cycles → `db_level_o` rises exactly after edge E+1002. `db_tick_o` is high for exactly 1 cycle, coincident with that edge.
3. **Bouncy press:** toggle `sw_i` with random high/low runs of 1–50 cycles for 500 cycles, then hold 1 → no output change during bouncing. Level rises 1002 edges after the final 0→1 sample, with exactly one tick.
4. **Release and release-bounce:** from ONE, apply `sw_i`=0 for 999 cycles, then 1 → `db_level_o` stays 1. Then hold 0 → level falls after 1002 edges, with no tick.
5. **Short pulses:** high pulse of 999 cycles from ZERO → `db_level_o` stays 0 and no tick. High pulse of 1001 cycles → level rises and one tick is produced.
6. **Mid-operation reset:** assert `rst_i`=0 while in WAIT1 (`cnt` ≈ 500) → next cycle all outputs are 0 and the state is ZERO. Qualification restarts from zero after release.
